// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern sequencer: FSM encoding, a width helper
// and elaboration-time parameter legality checks.
package led_pkg;

   typedef enum logic {
      ST_SHOW = 1'b0,
      ST_GAP  = 1'b1
   } state_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << r) < v) r = r + 1;
      end
      return r;
   endfunction

   function automatic bit params_ok(input int num_ch, input int sel_w, input int def_ch,
                                    input int gap_ticks);
      return (num_ch >= 2) && (num_ch <= 16) && ((1 << sel_w) >= num_ch) &&
             (def_ch >= 0) && (def_ch < num_ch) && (gap_ticks >= 0);
   endfunction

endpackage

// File: rtl/led_pattern_sequencer_tick_counter.sv
// Tick-gated counter with synchronous clear and a terminal-count compare against a live limit.
module tick_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_en,
   input  logic         i_clr,
   input  logic [W-1:0] i_limit,
   output logic         o_tc
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + W'(1);
      end
   end

   // Greater-or-equal so a limit lowered mid-period still terminates on the next tick.
   assign o_tc = (r_cnt >= i_limit);

endmodule

// File: rtl/led_pattern_sequencer.sv
// Registered N-channel LED pattern selector with manual/auto channel selection and a
// blanking gap inserted on every channel change.
module led_pattern_sequencer
   import led_pkg::*;
#(
   parameter int WIDTH      = 18,
   parameter int NUM_CH     = 6,
   parameter int SEL_W      = 4,
   parameter int DWELL_W    = 16,
   parameter int GAP_TICKS  = 2,
   parameter int DEFAULT_CH = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_CH*WIDTH-1:0] led_in,
   input  logic                    tick,
   input  logic [SEL_W-1:0]        sel_in,
   input  logic                    sel_load,
   input  logic                    auto_en,
   input  logic [DWELL_W-1:0]      dwell,
   input  logic                    blank,
   output logic [WIDTH-1:0]        led_out,
   output logic [SEL_W-1:0]        cur_sel,
   output logic                    busy,
   output logic                    wrap,
   output logic                    sel_err
);

   localparam int GAP_CW = (GAP_TICKS > 0) ? clog2(GAP_TICKS + 1) : 1;

   if (!params_ok(NUM_CH, SEL_W, DEFAULT_CH, GAP_TICKS)) begin : g_param_check
      $error("led_pattern_sequencer: illegal parameter combination");
   end

   state_t             r_state, w_state_nxt;
   logic [SEL_W-1:0]   r_cur_sel, w_cur_nxt;
   logic [SEL_W-1:0]   r_target, w_tgt_nxt;
   logic [WIDTH-1:0]   r_led_out, w_led_nxt;
   logic               r_wrap, w_wrap_nxt;
   logic               r_sel_err, w_err_nxt;

   logic [WIDTH-1:0]   w_ch [NUM_CH];
   logic [WIDTH-1:0]   w_sel_pat;
   logic               w_sel_valid, w_load_ok;
   logic [SEL_W-1:0]   w_next_ch;
   logic [DWELL_W-1:0] w_dwell_lim;
   logic               w_dwell_en, w_dwell_clr, w_dwell_tc;
   logic               w_gap_done;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
      assign w_ch[k] = led_in[k*WIDTH +: WIDTH];
   end

   always_comb begin
      w_sel_pat = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (r_cur_sel == SEL_W'(k)) w_sel_pat = w_ch[k];
      end
   end

   assign w_sel_valid = (32'(sel_in) < NUM_CH);
   assign w_load_ok   = sel_load & w_sel_valid;
   assign w_next_ch   = (r_cur_sel == SEL_W'(NUM_CH - 1)) ? '0 : r_cur_sel + SEL_W'(1);
   // A dwell of 0 behaves as 1: terminal count stays at 0.
   assign w_dwell_lim = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
   assign w_dwell_en  = tick & auto_en & (r_state == ST_SHOW);

   tick_counter #(.W(DWELL_W)) u_dwell (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_en    (w_dwell_en),
      .i_clr   (w_dwell_clr),
      .i_limit (w_dwell_lim),
      .o_tc    (w_dwell_tc)
   );

   if (GAP_TICKS > 0) begin : g_gap
      logic w_gap_tc;
      logic w_gap_en;

      assign w_gap_en   = tick & (r_state == ST_GAP);
      assign w_gap_done = w_gap_en & w_gap_tc;

      tick_counter #(.W(GAP_CW)) u_gap (
         .clk     (clk),
         .rst_n   (rst_n),
         .i_en    (w_gap_en),
         .i_clr   (w_gap_done),
         .i_limit (GAP_CW'(GAP_TICKS - 1)),
         .o_tc    (w_gap_tc)
      );
   end else begin : g_no_gap
      assign w_gap_done = 1'b0;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cur_nxt   = r_cur_sel;
      w_tgt_nxt   = r_target;
      w_wrap_nxt  = 1'b0;
      w_err_nxt   = sel_load & ~w_sel_valid;
      w_dwell_clr = ~auto_en;
      w_led_nxt   = (r_state == ST_GAP || blank) ? '0 : w_sel_pat;

      case (r_state)
         ST_SHOW: begin
            if (w_load_ok) begin
               // A manual request always beats a coincident auto advance.
               w_dwell_clr = 1'b1;
               if (sel_in != r_cur_sel) begin
                  if (GAP_TICKS == 0) begin
                     w_cur_nxt = sel_in;
                  end else begin
                     w_tgt_nxt   = sel_in;
                     w_state_nxt = ST_GAP;
                  end
               end
            end else if (auto_en && tick && w_dwell_tc) begin
               w_dwell_clr = 1'b1;
               w_wrap_nxt  = (r_cur_sel == SEL_W'(NUM_CH - 1));
               if (GAP_TICKS == 0) begin
                  w_cur_nxt = w_next_ch;
               end else begin
                  w_tgt_nxt   = w_next_ch;
                  w_state_nxt = ST_GAP;
               end
            end
         end
         ST_GAP: begin
            if (w_load_ok) w_tgt_nxt = sel_in;
            if (w_gap_done) begin
               w_cur_nxt   = w_load_ok ? sel_in : r_target;
               w_state_nxt = ST_SHOW;
            end
         end
         default: w_state_nxt = ST_SHOW;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= ST_SHOW;
         r_cur_sel <= SEL_W'(DEFAULT_CH);
         r_target  <= SEL_W'(DEFAULT_CH);
         r_led_out <= '0;
         r_wrap    <= 1'b0;
         r_sel_err <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cur_sel <= w_cur_nxt;
         r_target  <= w_tgt_nxt;
         r_led_out <= w_led_nxt;
         r_wrap    <= w_wrap_nxt;
         r_sel_err <= w_err_nxt;
      end
   end

   // During a gap the pending target is reported so software sees where it is heading.
   assign led_out = r_led_out;
   assign cur_sel = (r_state == ST_GAP) ? r_target : r_cur_sel;
   assign busy    = (r_state == ST_GAP);
   assign wrap    = r_wrap;
   assign sel_err = r_sel_err;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_led_pattern_sequencer;

   localparam int W   = 18;
   localparam int NCH = 6;
   localparam int SW  = 4;
   localparam int DW  = 16;
   localparam int GAP = 2;

   logic              clk;
   logic              rst_n;
   logic [NCH*W-1:0]  led_in;
   logic              tick;
   logic [SW-1:0]     sel_in;
   logic              sel_load;
   logic              auto_en;
   logic [DW-1:0]     dwell;
   logic              blank;
   logic [W-1:0]      led_out;
   logic [SW-1:0]     cur_sel;
   logic              busy;
   logic              wrap;
   logic              sel_err;

   led_pattern_sequencer #(
      .WIDTH(W), .NUM_CH(NCH), .SEL_W(SW), .DWELL_W(DW), .GAP_TICKS(GAP), .DEFAULT_CH(0)
   ) dut (
      .clk(clk), .rst_n(rst_n), .led_in(led_in), .tick(tick), .sel_in(sel_in),
      .sel_load(sel_load), .auto_en(auto_en), .dwell(dwell), .blank(blank),
      .led_out(led_out), .cur_sel(cur_sel), .busy(busy), .wrap(wrap), .sel_err(sel_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural model: which channel is shown, where we are heading, how many gap
   // ticks remain and how many ticks have been spent on the current channel.
   int         m_shown, m_target, m_gap_left, m_ticks, m_lim, m_nxt;
   bit         m_valid;
   bit         m_armed = 1'b0;
   logic [W-1:0] e_led;
   logic       e_wrap, e_err;

   always @(posedge clk) begin
      m_armed = 1'b1;
      if (!rst_n) begin
         m_shown = 0; m_target = 0; m_gap_left = 0; m_ticks = 0;
         e_led = '0; e_wrap = 1'b0; e_err = 1'b0;
      end else begin
         e_led   = (m_gap_left > 0 || blank) ? '0 : led_in[m_shown*W +: W];
         e_wrap  = 1'b0;
         m_valid = sel_load && (int'(sel_in) < NCH);
         e_err   = sel_load && !m_valid;
         if (m_gap_left > 0) begin
            if (m_valid) m_target = int'(sel_in);
            if (tick) begin
               m_gap_left = m_gap_left - 1;
               if (m_gap_left == 0) m_shown = m_target;
            end
         end else if (m_valid) begin
            m_ticks = 0;
            if (int'(sel_in) != m_shown) begin
               m_target = int'(sel_in);
               m_gap_left = GAP;
            end
         end else if (!auto_en) begin
            m_ticks = 0;
         end else if (tick) begin
            m_lim = (dwell == 0) ? 1 : int'(dwell);
            if (m_ticks + 1 >= m_lim) begin
               m_nxt = (m_shown + 1) % NCH;
               e_wrap = (m_nxt == 0);
               m_ticks = 0;
               m_target = m_nxt;
               m_gap_left = GAP;
            end else begin
               m_ticks = m_ticks + 1;
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, req);
      end
   endtask

   task automatic check_model();
      if (m_armed) begin
         chk("model_led_out", 32'(led_out), 32'(e_led));
         chk("model_busy", 32'(busy), 32'(m_gap_left > 0));
         chk("model_cur_sel", 32'(cur_sel), (m_gap_left > 0) ? m_target : m_shown);
         chk("model_wrap", 32'(wrap), 32'(e_wrap));
         chk("model_sel_err", 32'(sel_err), 32'(e_err));
      end
   endtask

   task automatic clk1();
      @(posedge clk);
      @(negedge clk);
      check_model();
   endtask

   initial begin
      rst_n = 1'b0; tick = 1'b0; sel_in = '0; sel_load = 1'b0;
      auto_en = 1'b0; dwell = '0; blank = 1'b0; led_in = '0;
      for (int k = 0; k < NCH; k++) led_in[k*W +: W] = W'(1) << (3*k);

      // 1: reset and release
      clk1(); clk1();
      chk("t1_rst_led", 32'(led_out), 32'h0);
      chk("t1_rst_busy", 32'(busy), 32'h0);
      chk("t1_rst_cur", 32'(cur_sel), 32'h0);
      rst_n = 1'b1;
      clk1();
      chk("t1_led", 32'(led_out), 32'h00001);
      chk("t1_model_led", 32'(e_led), 32'h00001);
      chk("t1_busy", 32'(busy), 32'h0);
      chk("t1_cur", 32'(cur_sel), 32'h0);

      // 2: manual select of channel 3 with a two-tick gap
      sel_in = 4'd3; sel_load = 1'b1; clk1(); sel_load = 1'b0;
      chk("t2_busy_start", 32'(busy), 32'h1);
      chk("t2_cur_target", 32'(cur_sel), 32'h3);
      clk1();
      chk("t2_gap_led", 32'(led_out), 32'h0);
      tick = 1'b1; clk1(); tick = 1'b0;
      chk("t2_busy_mid", 32'(busy), 32'h1);
      clk1();
      tick = 1'b1; clk1(); tick = 1'b0;
      chk("t2_busy_end", 32'(busy), 32'h0);
      chk("t2_cur_end", 32'(cur_sel), 32'h3);
      clk1();
      chk("t2_led_ch3", 32'(led_out), 32'h00200);
      chk("t2_model_led_ch3", 32'(e_led), 32'h00200);

      // 4: out-of-range select
      sel_in = 4'd7; sel_load = 1'b1; clk1(); sel_load = 1'b0;
      chk("t4_sel_err", 32'(sel_err), 32'h1);
      chk("t4_cur", 32'(cur_sel), 32'h3);
      chk("t4_busy", 32'(busy), 32'h0);
      clk1();
      chk("t4_sel_err_drop", 32'(sel_err), 32'h0);
      chk("t4_led", 32'(led_out), 32'h00200);

      // 3: park on channel 5, then auto-advance with dwell=4 and dwell=0
      sel_in = 4'd5; sel_load = 1'b1; clk1(); sel_load = 1'b0;
      tick = 1'b1; clk1(); clk1(); tick = 1'b0; clk1();
      chk("t3_at_ch5", 32'(cur_sel), 32'h5);
      auto_en = 1'b1; dwell = 16'd4; clk1();
      for (int i = 0; i < 3; i++) begin
         tick = 1'b1; clk1(); tick = 1'b0; clk1();
      end
      chk("t3_no_early_adv", 32'(busy), 32'h0);
      tick = 1'b1; clk1(); tick = 1'b0;
      chk("t3_wrap", 32'(wrap), 32'h1);
      chk("t3_busy", 32'(busy), 32'h1);
      chk("t3_cur_wrapped", 32'(cur_sel), 32'h0);
      clk1();
      chk("t3_wrap_drop", 32'(wrap), 32'h0);
      dwell = '0;
      tick = 1'b1; clk1(); clk1(); tick = 1'b0; clk1();
      chk("t3_show_ch0", 32'(busy), 32'h0);
      tick = 1'b1; clk1(); tick = 1'b0;
      chk("t3_dwell0_busy", 32'(busy), 32'h1);
      chk("t3_dwell0_cur", 32'(cur_sel), 32'h1);

      // 5: manual select coincident with an auto advance from channel 0
      auto_en = 1'b0; sel_in = 4'd0; sel_load = 1'b1; clk1(); sel_load = 1'b0;
      tick = 1'b1; clk1(); clk1(); tick = 1'b0; clk1();
      chk("t5_at_ch0", 32'(cur_sel), 32'h0);
      auto_en = 1'b1; dwell = '0; sel_in = 4'd2; sel_load = 1'b1; tick = 1'b1;
      clk1(); sel_load = 1'b0; tick = 1'b0;
      chk("t5_cur_target", 32'(cur_sel), 32'h2);
      chk("t5_no_wrap", 32'(wrap), 32'h0);
      chk("t5_busy", 32'(busy), 32'h1);

      // 6: reset in the middle of a gap, then blank while showing
      auto_en = 1'b0; rst_n = 1'b0; clk1(); rst_n = 1'b1;
      chk("t6_rst_busy", 32'(busy), 32'h0);
      chk("t6_rst_cur", 32'(cur_sel), 32'h0);
      blank = 1'b1; clk1(); clk1();
      chk("t6_blank_led", 32'(led_out), 32'h0);
      chk("t6_blank_cur", 32'(cur_sel), 32'h0);
      blank = 1'b0; clk1();
      chk("t6_unblank_led", 32'(led_out), 32'h00001);

      // Randomized traffic, checked every cycle against the model
      for (int n = 0; n < 4000; n++) begin
         rst_n    = ($urandom_range(0, 199) != 0);
         tick     = 1'($urandom_range(0, 1));
         sel_load = ($urandom_range(0, 7) == 0);
         sel_in   = ($urandom_range(0, 3) == 0) ? SW'($urandom_range(6, 15))
                                                : SW'($urandom_range(0, 5));
         if ($urandom_range(0, 49) == 0) auto_en = ~auto_en;
         if ($urandom_range(0, 9) == 0) dwell = DW'($urandom_range(0, 5));
         blank    = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 15) == 0) begin
            for (int k = 0; k < NCH; k++) led_in[k*W +: W] = W'($urandom);
         end
         clk1();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
